mc_sequencer: RTL

- Parametrised multi-cycle phase controller for the RV32 core.
- Sequences each instruction through IF, ID, EX, optional MM and WB, and owns the PC and instruction register (IR).
- Talks to instruction and data memory through req/ack handshakes with arbitrary wait states. Skips MM for non-memory instructions.
- Adds run/halt/single-step control, a retired-instruction counter and watchdog error detection, none of which the fixed 5-phase controller had.

---
 rtl/mc_pkg.sv | 21 ++
 rtl/mc_watchdog.sv | 30 +++
 rtl/mc_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared state encodings, error codes and reset vector for the multi-cycle sequencer.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MM   = 3'd4,
        ST_WB   = 3'd5,
        ST_ERR  = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_IMEM  = 2'd1;
    localparam logic [1:0] ERR_DMEM  = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    localparam logic [31:0] MC_RESET_VEC = 32'd2048;

endpackage

// File: rtl/mc_watchdog.sv
// Counts consecutive armed cycles without an ack; expired flags the cycle in which
// the count reaches TIMEOUT. TIMEOUT = 0 disables it.
module mc_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic ack,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!arm || ack || (TIMEOUT == 0)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // cnt holds the waits already seen, so this cycle is wait number cnt+1.
    assign expired = (TIMEOUT != 0) && arm && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle IF/ID/EX/MM/WB phase controller owning PC and IR, with run/halt/step
// control, a retired counter and a shared memory-ack watchdog.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(MC_RESET_VEC),
    parameter int              TIMEOUT   = 16,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    input  logic             dec_is_mem,
    input  logic             dec_is_store,
    input  logic             dec_rf_wr,
    input  logic [XLEN-1:0]  next_pc,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic [XLEN-1:0]  pc,
    output logic [2:0]       phase,
    output logic             halted,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    state_t          state, state_nxt;
    logic            step_mode, step_mode_nxt;
    logic [1:0]      err_code_nxt;
    logic            is_store_q, rf_wr_q;
    logic            is_store_d, rf_wr_d;
    logic [XLEN-1:0] next_pc_q;
    logic            wd_arm, wd_ack, wd_expired;
    logic            misaligned;

    assign wd_arm     = (state == ST_IF) || (state == ST_MM);
    assign wd_ack     = ((state == ST_IF) && imem_ack) || ((state == ST_MM) && dmem_ack);
    assign misaligned = (next_pc_q[1:0] != 2'b00);

    // Decode flags are captured at the end of EX; registered strobes for the
    // following phase must see the live values during that same cycle.
    assign is_store_d = (state == ST_EX) ? dec_is_store : is_store_q;
    assign rf_wr_d    = (state == ST_EX) ? dec_rf_wr    : rf_wr_q;

    assign halted    = (state == ST_HALT);
    assign imem_addr = pc;
    assign phase     = state;

    mc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .arm     (wd_arm),
        .ack     (wd_ack),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt     = state;
        step_mode_nxt = step_mode;
        err_code_nxt  = err_code;
        case (state)
            ST_HALT: begin
                if (run) begin
                    state_nxt     = ST_IF;
                    step_mode_nxt = 1'b0;
                end else if (step) begin
                    state_nxt     = ST_IF;
                    step_mode_nxt = 1'b1;
                end
            end
            ST_IF: begin
                if (imem_ack) begin
                    state_nxt = ST_ID;
                end else if (wd_expired) begin
                    state_nxt    = ST_ERR;
                    err_code_nxt = ERR_IMEM;
                end
            end
            ST_ID:   state_nxt = ST_EX;
            ST_EX:   state_nxt = dec_is_mem ? ST_MM : ST_WB;
            ST_MM: begin
                if (dmem_ack) begin
                    state_nxt = ST_WB;
                end else if (wd_expired) begin
                    state_nxt    = ST_ERR;
                    err_code_nxt = ERR_DMEM;
                end
            end
            ST_WB: begin
                if (misaligned) begin
                    state_nxt    = ST_ERR;
                    err_code_nxt = ERR_ALIGN;
                end else if (halt_req || step_mode) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_IF;
                end
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_HALT;
            step_mode <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_mode <= step_mode_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_VEC;
            ir         <= '0;
            retired    <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            imem_req   <= 1'b0;
            alu_en     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            rf_we      <= 1'b0;
            is_store_q <= 1'b0;
            rf_wr_q    <= 1'b0;
            next_pc_q  <= '0;
        end else begin
            err      <= (state_nxt == ST_ERR);
            err_code <= err_code_nxt;
            imem_req <= (state_nxt == ST_IF);
            alu_en   <= (state_nxt == ST_EX);
            dmem_req <= (state_nxt == ST_MM);
            dmem_we  <= (state_nxt == ST_MM) && is_store_d;
            rf_we    <= (state_nxt == ST_WB) && rf_wr_d;
            if ((state == ST_IF) && imem_ack) begin
                ir <= imem_rdata;
            end
            if (state == ST_EX) begin
                is_store_q <= dec_is_store;
                rf_wr_q    <= dec_rf_wr;
                next_pc_q  <= next_pc;
            end
            if ((state == ST_WB) && !misaligned) begin
                pc      <= next_pc_q;
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule
